// File: rtl/snake_pkg.sv
// Shared snake-game definitions: playfield/pixel geometry defaults, cell coordinate
// widths and the food position generator state encoding.
package snake_pkg;

    localparam int GRID_W_DEF    = 20;
    localparam int GRID_H_DEF    = 20;
    localparam int CELL_PX_DEF   = 25;
    localparam int ORIGIN_PX_DEF = 2;

    localparam int CX_W = $clog2(GRID_W_DEF);
    localparam int CY_W = $clog2(GRID_H_DEF);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DRAW  = 3'd1,
        QUERY = 3'd2,
        WAIT  = 3'd3,
        SCAN  = 3'd4,
        SWAIT = 3'd5,
        DONE  = 3'd6
    } fpg_state_e;

endpackage

// File: rtl/lfsr_galois.sv
// Free-running Galois LFSR with a loadable seed; a zero seed is replaced by SEED
// so the register can never lock up in the all-zero state.
module lfsr_galois #(
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'h0001
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_value,
    output logic [LFSR_W-1:0] value
);

    logic [LFSR_W-1:0] value_r;
    logic [LFSR_W-1:0] value_next_s;

    // Next value: seed load wins over the per-cycle advance
    always_comb begin
        value_next_s = value_r;
        if (load) begin
            if (load_value == {LFSR_W{1'b0}}) begin
                value_next_s = SEED;
            end else begin
                value_next_s = load_value;
            end
        end else begin
            value_next_s = {1'b0, value_r[LFSR_W-1:1]} ^ (value_r[0] ? LFSR_TAPS : {LFSR_W{1'b0}});
        end
    end

    // Shift register
    always_ff @(posedge clock) begin
        if (reset) begin
            value_r <= SEED;
        end else begin
            value_r <= value_next_s;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/food_position_generator.sv
// Picks a free playfield cell for the snake food: random draws checked against the
// body store, then a row-major fallback scan that flags a completely full grid.
module food_position_generator
    import snake_pkg::*;
#(
    parameter int                GRID_W    = GRID_W_DEF,
    parameter int                GRID_H    = GRID_H_DEF,
    parameter int                CELL_PX   = CELL_PX_DEF,
    parameter int                ORIGIN_PX = ORIGIN_PX_DEF,
    parameter int                PIX_W     = 10,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter logic [LFSR_W-1:0] SEED      = 16'h0001,
    parameter int                MAX_TRIES = 15,
    localparam int               COL_W     = $clog2(GRID_W),
    localparam int               ROW_W     = $clog2(GRID_H)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_in,
    output logic              occ_query_valid,
    output logic [COL_W-1:0]  occ_query_x,
    output logic [ROW_W-1:0]  occ_query_y,
    input  logic              occ_hit,
    output logic              busy,
    output logic              done,
    output logic              grid_full,
    output logic [COL_W-1:0]  cell_x,
    output logic [ROW_W-1:0]  cell_y,
    output logic [PIX_W-1:0]  pix_x,
    output logic [PIX_W-1:0]  pix_y
);

    localparam int               TRY_W       = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0] MAX_TRIES_V = TRY_W'(MAX_TRIES);
    localparam logic [COL_W:0]   GRID_W_V    = (COL_W + 1)'(GRID_W);
    localparam logic [ROW_W:0]   GRID_H_V    = (ROW_W + 1)'(GRID_H);
    localparam logic [COL_W-1:0] LAST_X      = COL_W'(GRID_W - 1);
    localparam logic [ROW_W-1:0] LAST_Y      = ROW_W'(GRID_H - 1);

    if ((GRID_W - 1) * CELL_PX + ORIGIN_PX >= 2 ** PIX_W) begin : g_pix_x_overflow
        $error("food_position_generator: column pixel coordinate does not fit in PIX_W");
    end
    if ((GRID_H - 1) * CELL_PX + ORIGIN_PX >= 2 ** PIX_W) begin : g_pix_y_overflow
        $error("food_position_generator: row pixel coordinate does not fit in PIX_W");
    end
    if (LFSR_W < COL_W + ROW_W) begin : g_lfsr_too_narrow
        $error("food_position_generator: LFSR_W narrower than one cell candidate");
    end

    fpg_state_e       state_r, state_next_s;
    logic [TRY_W-1:0] tries_r, tries_next_s;
    logic [COL_W-1:0] cand_x_r, cand_x_next_s, scan_x_r, scan_x_next_s, result_x_s;
    logic [ROW_W-1:0] cand_y_r, cand_y_next_s, scan_y_r, scan_y_next_s, result_y_s;
    logic             grid_full_r, grid_full_next_s, load_result_s;
    logic             busy_r, done_r, occ_query_valid_r;
    logic [COL_W-1:0] occ_query_x_r, cell_x_r;
    logic [ROW_W-1:0] occ_query_y_r, cell_y_r;
    logic [PIX_W-1:0] pix_x_r, pix_y_r;
    logic [LFSR_W-1:0] lfsr_s;
    logic             lfsr_unused_s;
    logic [COL_W-1:0] draw_x_s;
    logic [ROW_W-1:0] draw_y_s;

    lfsr_galois #(
        .LFSR_W    (LFSR_W),
        .LFSR_TAPS (LFSR_TAPS),
        .SEED      (SEED)
    ) u_lfsr (
        .clock      (clock),
        .reset      (reset),
        .load       (seed_load),
        .load_value (seed_in),
        .value      (lfsr_s)
    );

    assign draw_x_s      = lfsr_s[COL_W-1:0];
    assign draw_y_s      = lfsr_s[COL_W+ROW_W-1:COL_W];
    assign lfsr_unused_s = ^lfsr_s;

    // Next-state, draw/scan bookkeeping and result selection
    always_comb begin
        state_next_s     = state_r;
        tries_next_s     = tries_r;
        cand_x_next_s    = cand_x_r;
        cand_y_next_s    = cand_y_r;
        scan_x_next_s    = scan_x_r;
        scan_y_next_s    = scan_y_r;
        grid_full_next_s = grid_full_r;
        load_result_s    = 1'b0;
        result_x_s       = cand_x_r;
        result_y_s       = cand_y_r;
        case (state_r)
            IDLE: begin
                if (req) begin
                    state_next_s     = DRAW;
                    tries_next_s     = {TRY_W{1'b0}};
                    grid_full_next_s = 1'b0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAW: begin
                if (tries_r >= MAX_TRIES_V) begin
                    state_next_s  = SCAN;
                    scan_x_next_s = {COL_W{1'b0}};
                    scan_y_next_s = {ROW_W{1'b0}};
                end else if (({1'b0, draw_x_s} >= GRID_W_V) || ({1'b0, draw_y_s} >= GRID_H_V)) begin
                    tries_next_s = tries_r + 1'b1;
                    if (tries_next_s >= MAX_TRIES_V) begin
                        state_next_s  = SCAN;
                        scan_x_next_s = {COL_W{1'b0}};
                        scan_y_next_s = {ROW_W{1'b0}};
                    end else begin
                        state_next_s = DRAW;
                    end
                end else begin
                    cand_x_next_s = draw_x_s;
                    cand_y_next_s = draw_y_s;
                    state_next_s  = QUERY;
                end
            end
            QUERY: state_next_s = WAIT;
            WAIT: begin
                if (occ_hit) begin
                    tries_next_s = tries_r + 1'b1;
                    if (tries_next_s >= MAX_TRIES_V) begin
                        state_next_s  = SCAN;
                        scan_x_next_s = {COL_W{1'b0}};
                        scan_y_next_s = {ROW_W{1'b0}};
                    end else begin
                        state_next_s = DRAW;
                    end
                end else begin
                    state_next_s  = DONE;
                    load_result_s = 1'b1;
                end
            end
            SCAN: state_next_s = SWAIT;
            SWAIT: begin
                if (!occ_hit) begin
                    state_next_s  = DONE;
                    load_result_s = 1'b1;
                    result_x_s    = scan_x_r;
                    result_y_s    = scan_y_r;
                end else if ((scan_x_r == LAST_X) && (scan_y_r == LAST_Y)) begin
                    // Grid exhausted: report full and keep the previous position
                    state_next_s     = DONE;
                    grid_full_next_s = 1'b1;
                end else if (scan_x_r == LAST_X) begin
                    scan_x_next_s = {COL_W{1'b0}};
                    scan_y_next_s = scan_y_r + 1'b1;
                    state_next_s  = SCAN;
                end else begin
                    scan_x_next_s = scan_x_r + 1'b1;
                    state_next_s  = SCAN;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // FSM state and search bookkeeping registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r  <= IDLE;
            tries_r  <= {TRY_W{1'b0}};
            cand_x_r <= {COL_W{1'b0}};
            cand_y_r <= {ROW_W{1'b0}};
            scan_x_r <= {COL_W{1'b0}};
            scan_y_r <= {ROW_W{1'b0}};
        end else begin
            state_r  <= state_next_s;
            tries_r  <= tries_next_s;
            cand_x_r <= cand_x_next_s;
            cand_y_r <= cand_y_next_s;
            scan_x_r <= scan_x_next_s;
            scan_y_r <= scan_y_next_s;
        end
    end

    // Registered outputs, decoded from the next state so they align with it
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_r            <= 1'b0;
            done_r            <= 1'b0;
            grid_full_r       <= 1'b0;
            occ_query_valid_r <= 1'b0;
            occ_query_x_r     <= {COL_W{1'b0}};
            occ_query_y_r     <= {ROW_W{1'b0}};
            cell_x_r          <= {COL_W{1'b0}};
            cell_y_r          <= {ROW_W{1'b0}};
            pix_x_r           <= PIX_W'(ORIGIN_PX);
            pix_y_r           <= PIX_W'(ORIGIN_PX);
        end else begin
            busy_r            <= (state_next_s != IDLE);
            done_r            <= (state_next_s == DONE);
            grid_full_r       <= grid_full_next_s;
            occ_query_valid_r <= (state_next_s == QUERY) || (state_next_s == SCAN);
            occ_query_x_r     <= (state_next_s == SCAN) ? scan_x_next_s : cand_x_next_s;
            occ_query_y_r     <= (state_next_s == SCAN) ? scan_y_next_s : cand_y_next_s;
            if (load_result_s) begin
                cell_x_r <= result_x_s;
                cell_y_r <= result_y_s;
                pix_x_r  <= PIX_W'(result_x_s) * PIX_W'(CELL_PX) + PIX_W'(ORIGIN_PX);
                pix_y_r  <= PIX_W'(result_y_s) * PIX_W'(CELL_PX) + PIX_W'(ORIGIN_PX);
            end else begin
                cell_x_r <= cell_x_r;
                cell_y_r <= cell_y_r;
                pix_x_r  <= pix_x_r;
                pix_y_r  <= pix_y_r;
            end
        end
    end

    assign busy            = busy_r;
    assign done            = done_r;
    assign grid_full       = grid_full_r;
    assign occ_query_valid = occ_query_valid_r;
    assign occ_query_x     = occ_query_x_r;
    assign occ_query_y     = occ_query_y_r;
    assign cell_x          = cell_x_r;
    assign cell_y          = cell_y_r;
    assign pix_x           = pix_x_r;
    assign pix_y           = pix_y_r;

endmodule

// File: tb/tb_food_position_generator.sv
// Directed bench for food_position_generator with a behavioural occupancy responder.
module tb_food_position_generator;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'h0000;
    logic        occ_hit = 1'b0;
    logic        occ_query_valid, busy, done, grid_full;
    logic [4:0]  occ_query_x, occ_query_y, cell_x, cell_y;
    logic [9:0]  pix_x, pix_y;

    int   checks = 0;
    int   failures = 0;
    logic occ_map [0:19][0:19];
    logic hit_pending = 1'b0;

    food_position_generator dut (
        .clock           (clock),
        .reset           (reset),
        .req             (req),
        .seed_load       (seed_load),
        .seed_in         (seed_in),
        .occ_query_valid (occ_query_valid),
        .occ_query_x     (occ_query_x),
        .occ_query_y     (occ_query_y),
        .occ_hit         (occ_hit),
        .busy            (busy),
        .done            (done),
        .grid_full       (grid_full),
        .cell_x          (cell_x),
        .cell_y          (cell_y),
        .pix_x           (pix_x),
        .pix_y           (pix_y)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Body store model: answer each query in the cycle after it is issued
    always @(negedge clock) begin
        occ_hit = hit_pending;
        if (occ_query_valid === 1'b1) begin
            chk("query_in_range", {31'd0, (occ_query_x < 5'd20) && (occ_query_y < 5'd20)}, 32'd1);
            if ((occ_query_x < 5'd20) && (occ_query_y < 5'd20))
                hit_pending = occ_map[occ_query_x][occ_query_y];
            else
                hit_pending = 1'b1;
        end else begin
            hit_pending = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic fill_map(input logic v);
        for (int x = 0; x < 20; x++)
            for (int y = 0; y < 20; y++)
                occ_map[x][y] = v;
    endtask

    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        while ((done !== 1'b1) && (lat < budget)) begin
            tick();
            lat++;
        end
        chk("done_seen", {31'd0, done}, 32'd1);
    endtask

    task automatic request();
        req = 1'b1;
        tick();
        req = 1'b0;
    endtask

    task automatic check_cell(input string tag, input int ex, input int ey);
        chk({tag, "_cell_x"}, {27'd0, cell_x}, ex);
        chk({tag, "_cell_y"}, {27'd0, cell_y}, ey);
        chk({tag, "_pix_x"}, {22'd0, pix_x}, ex * 25 + 2);
        chk({tag, "_pix_y"}, {22'd0, pix_y}, ey * 25 + 2);
    endtask

    initial begin
        int lat;
        int ndone;
        fill_map(1'b0);

        // Reset state
        repeat (3) tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_grid_full", {31'd0, grid_full}, 32'd0);
        chk("rst_query_valid", {31'd0, occ_query_valid}, 32'd0);
        check_cell("rst", 0, 0);
        reset = 1'b0;
        tick();

        // Seed 0x0146 advances to 0x00A3 -> cell (3,5), minimum latency
        seed_load = 1'b1; seed_in = 16'h0146;
        tick();
        seed_load = 1'b0;
        request();
        chk("seed_busy", {31'd0, busy}, 32'd1);
        wait_done(20, lat);
        chk("seed_latency", lat, 3);
        check_cell("seed", 3, 5);
        chk("seed_grid_full", {31'd0, grid_full}, 32'd0);
        tick();
        chk("seed_done_pulse", {31'd0, done}, 32'd0);
        chk("seed_idle_busy", {31'd0, busy}, 32'd0);

        // Zero seed substitutes 0x0001: B400 then 5A00 -> cell (0,16)
        seed_load = 1'b1; seed_in = 16'h0000;
        tick();
        seed_load = 1'b0;
        tick();
        request();
        wait_done(20, lat);
        chk("zseed_latency", lat, 3);
        check_cell("zseed", 0, 16);
        tick();

        // req held through busy and the DONE cycle produces one result only
        seed_load = 1'b1; seed_in = 16'h0146;
        tick();
        seed_load = 1'b0;
        req = 1'b1;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        req = 1'b0;
        chk("hold_busy_after", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("hold_single_done", ndone, 1);
        check_cell("hold", 3, 5);

        // Range sweep with an empty board at random spacing
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 5)) tick();
            request();
            wait_done(100, lat);
            chk("sweep_x_range", {31'd0, cell_x < 5'd20}, 32'd1);
            chk("sweep_y_range", {31'd0, cell_y < 5'd20}, 32'd1);
            chk("sweep_pix_x", {22'd0, pix_x}, {27'd0, cell_x} * 25 + 2);
            chk("sweep_pix_y", {22'd0, pix_y}, {27'd0, cell_y} * 25 + 2);
            tick();
            chk("sweep_busy_low", {31'd0, busy}, 32'd0);
        end

        // Only (0..9, 19) free
        fill_map(1'b1);
        for (int x = 0; x < 10; x++) occ_map[x][19] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            request();
            wait_done(2000, lat);
            chk("avoid_row", {27'd0, cell_y}, 19);
            chk("avoid_col", {31'd0, cell_x < 5'd10}, 32'd1);
            chk("avoid_grid_full", {31'd0, grid_full}, 32'd0);
            chk("avoid_pix_y", {22'd0, pix_y}, 19 * 25 + 2);
            tick();
        end

        // Single free cell (2,0), reached by the fallback scan
        fill_map(1'b1);
        occ_map[2][0] = 1'b0;
        request();
        wait_done(2000, lat);
        check_cell("fallback", 2, 0);
        chk("fallback_grid_full", {31'd0, grid_full}, 32'd0);
        tick();

        // Completely full board
        fill_map(1'b1);
        request();
        wait_done(2000, lat);
        chk("full_latency_bound", {31'd0, lat <= 848}, 32'd1);
        chk("full_grid_full", {31'd0, grid_full}, 32'd1);
        check_cell("full", 2, 0);
        tick();

        // Next request clears grid_full
        fill_map(1'b0);
        request();
        wait_done(100, lat);
        chk("clear_grid_full", {31'd0, grid_full}, 32'd0);
        tick();

        // Reset in the middle of a scan
        fill_map(1'b1);
        occ_map[2][0] = 1'b0;
        request();
        wait_done(2000, lat);
        tick();
        fill_map(1'b1);
        request();
        repeat (150) tick();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_query", {31'd0, occ_query_valid}, 32'd0);
        check_cell("mid_rst", 0, 0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) ndone++;
        end
        chk("mid_rst_no_done", ndone, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/food_position_generator.md
Name: food_position_generator

Overview:
- Generates a pseudo-random free cell on a GRID_W x GRID_H playfield for the snake game's food item.
- Converts the chosen cell to pixel coordinates for the VGA renderer.
- Successor to the fixed 20x20 generator. Adds:
  - a parametrised grid and pixel geometry;
  - an LFSR random source with a loadable seed;
  - rejection of out-of-range cells;
  - an occupancy query handshake with the snake body store, so food never lands on the snake;
  - a deterministic fallback scan with a grid-full flag.
- Sits between the game-control FSM (requester) and the snake body memory (occupancy responder).

Parameters:
- GRID_W, 20, playfield columns (cells).
- GRID_H, 20, playfield rows (cells).
- CELL_PX, 25, pixel pitch of one cell.
- ORIGIN_PX, 2, pixel offset of cell 0 on both axes.
- PIX_W, 10, width of pixel coordinate outputs.
- LFSR_W, 16, LFSR width; must be >= CX_W+CY_W.
- LFSR_TAPS, 16'hB400, Galois feedback mask.
- SEED, 16'h0001, reset seed and substitute for a zero seed.
- MAX_TRIES, 15, random draws before switching to the fallback scan.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request a new position; sampled only in IDLE.
- seed_load  in  1  load seed_in into the LFSR; accepted in any state.
- seed_in  in  LFSR_W  new seed value.
- occ_query_valid  out  1  one-cycle query strobe to the body store.
- occ_query_x  out  CX_W  queried column; CX_W=$clog2(GRID_W).
- occ_query_y  out  CY_W  queried row; CY_W=$clog2(GRID_H).
- occ_hit  in  1  queried cell is occupied; valid exactly 1 cycle after occ_query_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a result is ready.
- grid_full  out  1  set with done when no free cell exists.
- cell_x  out  CX_W  result column (held).
- cell_y  out  CY_W  result row (held).
- pix_x  out  PIX_W  cell_x*CELL_PX+ORIGIN_PX (held).
- pix_y  out  PIX_W  cell_y*CELL_PX+ORIGIN_PX (held).

Behaviour:
- Reset values:
  - state IDLE, lfsr=SEED, tries=0.
  - busy=0, done=0, grid_full=0, occ_query_valid=0.
  - cell_x=cell_y=0, pix_x=pix_y=ORIGIN_PX.
- LFSR:
  - Galois, advances every cycle in all states (user timing adds entropy): lfsr <= (lfsr>>1) ^ (lfsr[0] ? LFSR_TAPS : 0).
  - seed_load overrides the advance for that cycle: lfsr <= seed_in, or SEED if seed_in==0.
- Candidate extraction: cx = lfsr[CX_W-1:0], cy = lfsr[CX_W+CY_W-1:CX_W], taken from the registered lfsr value while in DRAW.
- FSM states and transitions:
  - IDLE: on req, go to DRAW, clear tries and grid_full.
  - DRAW:
    - If cx>=GRID_W or cy>=GRID_H: tries++, stay in DRAW.
    - Otherwise: latch the candidate and go to QUERY.
    - If tries reaches MAX_TRIES: go to SCAN with the scan pointer at (0,0).
  - QUERY: occ_query_valid=1 with the latched candidate; go to WAIT.
  - WAIT: sample occ_hit.
    - 0: go to DONE.
    - 1: tries++, then DRAW, or SCAN if tries reaches MAX_TRIES.
  - SCAN: issue a query for the scan pointer; go to SWAIT.
  - SWAIT:
    - If occ_hit=0: latch the pointer and go to DONE.
    - Otherwise advance row-major (x++, wrap to 0 with y++).
    - After cell (GRID_W-1, GRID_H-1) is hit: set grid_full and go to DONE, leaving the outputs unchanged.
  - DONE:
    - done=1 for one cycle.
    - cell_*/pix_* update in this same cycle; pixel math is registered at DONE entry.
    - Return to IDLE.
- Timing:
  - Minimum latency: req at cycle t → done at t+4.
  - Worst case: bounded by MAX_TRIES draws plus 2*GRID_W*GRID_H cycles.
- Corner cases:
  - req while busy is ignored, not queued.
  - req in the cycle that DONE is active is ignored.
  - Reset mid-operation: return to IDLE with no done pulse. Outputs take their reset values.
- Arithmetic: pixel products are computed at PIX_W. Overflow is a configuration error, checked with an elaboration-time assertion: (GRID_W-1)*CELL_PX+ORIGIN_PX < 2**PIX_W, and the same for GRID_H.

Decomposition:
- Shared package snake_pkg holds:
  - the GRID_W/GRID_H/CELL_PX/ORIGIN_PX defaults;
  - CX_W/CY_W as localparams;
  - the FSM state enum (IDLE, DRAW, QUERY, WAIT, SCAN, SWAIT, DONE).
- One sub-module, lfsr_galois (parameters LFSR_W, LFSR_TAPS, SEED; ports clock, reset, load, load_value, value), reused by other game randomness.

Test Plan:
- Seed load, occ_hit=0: seed_load with seed_in=16'h0001 at t, req at t+1 → DRAW sees lfsr=16'hB400, query (0,0), done at t+5 with cell=(0,0), pix=(2,2).
- Range sweep: 10000 requests at random spacing, occ_hit=0 → every cell_x<20, cell_y<20; no done ever missing; busy low between results.
- Occupancy avoidance: body model occupies 390 of 400 cells → every result is one of the 10 free cells; occ_hit always sampled exactly 1 cycle after the query.
- Fallback: occ_hit=1 for the first 15 random queries, then model with (0,0),(1,0) occupied → SCAN returns cell=(2,0), pix=(52,2), grid_full=0.
- Full grid: all 400 cells occupied → done with grid_full=1, outputs unchanged, at most 15*3+800+3 cycles after req.
- Reset/seed robustness: reset asserted during SCAN → next cycle busy=0, done=0, pix=(2,2). seed_load with 0 → lfsr=16'h0001. req during busy → no extra done.
